// File: rtl/cache_ctrl_if.sv
// Core/memory bundle for the direct-mapped data cache.
// The slave modport is the cache; the master modport is the core plus memory.
interface cache_ctrl_if;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  rd_req, wr_req, addr, wr_data, wr_be,
    input  mem_rdata, mem_ack,
    output rd_data, miss,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, wr_req, addr, wr_data, wr_be,
    output mem_rdata, mem_ack,
    input  rd_data, miss,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache.
// Misses write back a dirty victim, then refill the line word by word.
module cache_ctrl #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int SET_ADDR_LEN  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);

  localparam int WORDS  = 1 << LINE_ADDR_LEN;
  localparam int SETS   = 1 << SET_ADDR_LEN;
  localparam int SET_LO = LINE_ADDR_LEN + 2;
  localparam int TAG_LO = SET_LO + SET_ADDR_LEN;
  localparam int TAG_W  = 32 - TAG_LO;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL,
    FILL_DONE
  } state_e;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  state_e                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
  logic [SET_ADDR_LEN-1:0]  set_q, set_d;
  logic [TAG_W-1:0]         mtag_q, mtag_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic [31:0]              mem_wdata_q, mem_wdata_d;

  logic [LINE_ADDR_LEN-1:0] req_off;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_W-1:0]         req_tag;
  logic [LINE_ADDR_LEN-1:0] cnt_nx;
  logic [LINE_ADDR_LEN-1:0] off0;
  logic                     req, hit, ack, last;
  logic                     hit_we, fill_we, fill_done;
  logic                     unused_lsb;

  assign req_off    = bus.addr[SET_LO-1:2];
  assign req_set    = bus.addr[TAG_LO-1:SET_LO];
  assign req_tag    = bus.addr[31:TAG_LO];
  assign unused_lsb = ^bus.addr[1:0];
  assign off0       = '0;

  assign req    = bus.rd_req | bus.wr_req;
  assign hit    = valid_q[req_set] && (tag_q[req_set] == req_tag);
  assign ack    = bus.mem_ack & mem_req_q;
  assign last   = (cnt_q == {LINE_ADDR_LEN{1'b1}});
  assign cnt_nx = cnt_q + 1'b1;

  assign bus.rd_data   = req ? data_q[req_set][req_off] : '0;
  assign bus.miss      = (state_q != IDLE) || (req && !hit);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    set_d       = set_q;
    mtag_d      = mtag_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_we      = 1'b0;
    fill_we     = 1'b0;
    fill_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          hit_we = bus.wr_req;
        end else if (req) begin
          set_d     = req_set;
          mtag_d    = req_tag;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (valid_q[req_set] && dirty_q[req_set]) begin
            state_d     = WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[req_set], req_set, off0, 2'b00};
            mem_wdata_d = data_q[req_set][0];
          end else begin
            state_d     = REFILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_tag, req_set, off0, 2'b00};
            mem_wdata_d = '0;
          end
        end
      end
      WB: begin
        if (ack && last) begin
          state_d     = REFILL;
          cnt_d       = '0;
          mem_we_d    = 1'b0;
          mem_addr_d  = {mtag_q, set_q, off0, 2'b00};
          mem_wdata_d = '0;
        end else if (ack) begin
          cnt_d       = cnt_nx;
          mem_addr_d  = {tag_q[set_q], set_q, cnt_nx, 2'b00};
          mem_wdata_d = data_q[set_q][cnt_nx];
        end
      end
      REFILL: begin
        fill_we = ack;
        if (ack && last) begin
          state_d    = FILL_DONE;
          cnt_d      = '0;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end else if (ack) begin
          cnt_d      = cnt_nx;
          mem_addr_d = {mtag_q, set_q, cnt_nx, 2'b00};
        end
      end
      FILL_DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      set_q       <= '0;
      mtag_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      mtag_q      <= mtag_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Line array: hit stores, refill words and the final tag/valid update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s] <= '0;
        for (int w = 0; w < WORDS; w++) begin
          data_q[s][w] <= '0;
        end
      end
    end else begin
      if (hit_we) begin
        dirty_q[req_set] <= 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (bus.wr_be[b]) begin
            data_q[req_set][req_off][8*b +: 8] <= bus.wr_data[8*b +: 8];
          end
        end
      end
      if (fill_we) begin
        data_q[set_q][cnt_q] <= bus.mem_rdata;
      end
      if (fill_done) begin
        tag_q[set_q]   <= mtag_q;
        valid_q[set_q] <= 1'b1;
        dirty_q[set_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a latency-configurable memory model.
// Table vectors cover hits/stores; hand sequences cover misses and reset.
module tb_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if ifc ();

  cache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic [31:0] mem [1024];
  xfer_t       log_q [$];
  int          lat = 2;
  bit          hold = 0;
  bit          stray = 0;
  int          wcnt = 0;

  task automatic do_xfer();
    xfer_t x;
    x.we = ifc.mem_we;
    x.a  = ifc.mem_addr;
    x.d  = ifc.mem_wdata;
    log_q.push_back(x);
    if (ifc.mem_we) mem[ifc.mem_addr[11:2]] = ifc.mem_wdata;
    else ifc.mem_rdata = mem[ifc.mem_addr[11:2]];
  endtask

  // Memory responder: L wait cycles then a one-cycle ack per word.
  always @(negedge clk) begin
    if (!rst_n) begin
      ifc.mem_ack = 1'b0;
      wcnt = 0;
    end else if (stray) begin
      ifc.mem_ack = 1'b1;
    end else if (hold) begin
      ifc.mem_ack = ifc.mem_req;
      if (ifc.mem_req) do_xfer();
    end else if (ifc.mem_ack) begin
      ifc.mem_ack = 1'b0;
      wcnt = 1;
    end else if (ifc.mem_req) begin
      if (wcnt >= lat) begin
        ifc.mem_ack = 1'b1;
        do_xfer();
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output bit first_miss, output int cyc);
    @(negedge clk);
    ifc.rd_req  = rd;
    ifc.wr_req  = wr;
    ifc.addr    = a;
    ifc.wr_data = d;
    ifc.wr_be   = be;
    #1;
    first_miss = ifc.miss;
    cyc = 0;
    while (ifc.miss && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("miss_timeout", {31'b0, ifc.miss}, 32'd0);
  endtask

  task automatic release_req();
    @(negedge clk);
    ifc.rd_req = 1'b0;
    ifc.wr_req = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          exp_miss;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [8];

  initial begin
    bit fm;
    int cyc;
    int n;
    logic [31:0] exp_a;

    vt[0] = '{1, 0, 32'h40, 32'h0, 4'h0, 1, 1, 32'hC0DE0040};
    vt[1] = '{1, 0, 32'h40, 32'h0, 4'h0, 0, 1, 32'hC0DE0040};
    vt[2] = '{1, 0, 32'h44, 32'h0, 4'h0, 0, 1, 32'h11223344};
    vt[3] = '{0, 1, 32'h44, 32'hDEADBEEF, 4'b0011, 0, 0, 32'h0};
    vt[4] = '{1, 0, 32'h44, 32'h0, 4'h0, 0, 1, 32'h1122BEEF};
    vt[5] = '{1, 0, 32'h4C, 32'h0, 4'h0, 0, 1, 32'hC0DE004C};
    vt[6] = '{1, 1, 32'h48, 32'hCAFEF00D, 4'b1111, 0, 0, 32'h0};
    vt[7] = '{1, 0, 32'h48, 32'h0, 4'h0, 0, 1, 32'hCAFEF00D};

    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
    mem[17] = 32'h11223344;

    ifc.rd_req    = 1'b0;
    ifc.wr_req    = 1'b0;
    ifc.addr      = '0;
    ifc.wr_data   = '0;
    ifc.wr_be     = '0;
    ifc.mem_rdata = '0;
    ifc.mem_ack   = 1'b0;

    #12;
    chk("rst_miss", {31'b0, ifc.miss}, 32'd0);
    chk("rst_rd_data", ifc.rd_data, 32'd0);
    chk("rst_mem_req", {31'b0, ifc.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, ifc.mem_we}, 32'd0);
    chk("rst_mem_addr", ifc.mem_addr, 32'd0);
    chk("rst_mem_wdata", ifc.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: first refill, hits, partial store, rd+wr treated as store
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].be, fm, cyc);
      chk($sformatf("vec%0d_miss", i), {31'b0, fm}, {31'b0, vt[i].exp_miss});
      if (vt[i].chk_rd)
        chk($sformatf("vec%0d_rd", i), ifc.rd_data, vt[i].exp_rd);
      if (i == 0) chk("clean_miss_cycles", cyc, 14);
      release_req();
    end
    chk("table_xfers", log_q.size(), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      chk($sformatf("refill%0d_addr", k), log_q[k].a, 32'h40 + 32'(k * 4));
      chk($sformatf("refill%0d_we", k), {31'b0, log_q[k].we}, 32'd0);
    end

    // Stray ack in IDLE must be ignored
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    #1;
    chk("stray_mem_req", {31'b0, ifc.mem_req}, 32'd0);
    chk("stray_miss", {31'b0, ifc.miss}, 32'd0);
    access(1, 0, 32'h4C, 32'h0, 4'h0, fm, cyc);
    chk("stray_hit", {31'b0, fm}, 32'd0);
    chk("stray_rd", ifc.rd_data, 32'hC0DE004C);
    release_req();

    // Dirty conflict miss: write back modified line, then refill
    log_q.delete();
    access(1, 0, 32'h440, 32'h0, 4'h0, fm, cyc);
    chk("conf_miss", {31'b0, fm}, 32'd1);
    chk("conf_cycles", cyc, 26);
    chk("conf_rd", ifc.rd_data, 32'hC0DE0440);
    release_req();
    chk("conf_xfers", log_q.size(), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      exp_a = (k < 4) ? 32'h40 + 32'(k * 4) : 32'h440 + 32'((k - 4) * 4);
      chk($sformatf("conf%0d_addr", k), log_q[k].a, exp_a);
      chk($sformatf("conf%0d_we", k), {31'b0, log_q[k].we},
          (k < 4) ? 32'd1 : 32'd0);
    end
    if (log_q.size() >= 4) begin
      chk("wb0_data", log_q[0].d, 32'hC0DE0040);
      chk("wb1_data", log_q[1].d, 32'h1122BEEF);
      chk("wb2_data", log_q[2].d, 32'hCAFEF00D);
      chk("wb3_data", log_q[3].d, 32'hC0DE004C);
    end

    // Clean valid victim with continuous ack: one word per cycle
    hold = 1;
    log_q.delete();
    access(1, 0, 32'h40, 32'h0, 4'h0, fm, cyc);
    chk("hold_miss", {31'b0, fm}, 32'd1);
    chk("hold_cycles", cyc, 6);
    chk("hold_rd", ifc.rd_data, 32'hC0DE0040);
    release_req();
    hold = 0;
    chk("hold_xfers", log_q.size(), 4);
    n = 0;
    foreach (log_q[k]) if (log_q[k].we) n++;
    chk("hold_no_wb", n, 0);
    access(1, 0, 32'h48, 32'h0, 4'h0, fm, cyc);
    chk("roundtrip_rd", ifc.rd_data, 32'hCAFEF00D);
    release_req();

    // Reset during the second write-back word
    access(0, 1, 32'h40, 32'h0BADF00D, 4'b1111, fm, cyc);
    chk("dirty_store_hit", {31'b0, fm}, 32'd0);
    release_req();
    log_q.delete();
    @(negedge clk);
    ifc.rd_req = 1'b1;
    ifc.addr   = 32'h440;
    n = 0;
    while (log_q.size() < 1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wb_started", log_q.size(), 1);
    @(negedge clk);
    #1;
    chk("wb2_addr", ifc.mem_addr, 32'h44);
    chk("wb2_we", {31'b0, ifc.mem_we}, 32'd1);
    rst_n = 1'b0;
    ifc.rd_req = 1'b0;
    #1;
    chk("mrst_mem_req", {31'b0, ifc.mem_req}, 32'd0);
    chk("mrst_mem_we", {31'b0, ifc.mem_we}, 32'd0);
    chk("mrst_mem_addr", ifc.mem_addr, 32'd0);
    chk("mrst_mem_wdata", ifc.mem_wdata, 32'd0);
    chk("mrst_miss", {31'b0, ifc.miss}, 32'd0);
    chk("mrst_rd_data", ifc.rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    access(1, 0, 32'h40, 32'h0, 4'h0, fm, cyc);
    chk("post_rst_miss", {31'b0, fm}, 32'd1);
    chk("post_rst_rd", ifc.rd_data, 32'h0BADF00D);
    release_req();
    n = 0;
    foreach (log_q[k]) if (log_q[k].we) n++;
    chk("post_rst_no_wb", n, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back, write-allocate data cache with its miss-handling controller. Sits between the core's MEM stage and main memory; supplies the aligned 32-bit word that the load-extension logic narrows by `addr[1:0]` and load type. Hits complete in zero wait cycles. Misses stall the pipeline through `miss` while the FSM writes back a dirty victim and refills the line, one word per memory handshake.

## Interface
- `LINE_ADDR_LEN`, default 2: log2 of words per line (4 words).
- `SET_ADDR_LEN`, default 3: log2 of sets (8 lines).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rd_req`  in  1  load request; held by the core while `miss`=1.
- `wr_req`  in  1  store request; held while `miss`=1.
- `addr`  in  32  byte address; `[1:0]` ignored by the cache.
- `wr_data`  in  32  store data, already lane-aligned.
- `wr_be`  in  4  store byte enables.
- `rd_data`  out  32  hit word, combinational from the line array.
- `miss`  out  1  stall; high while the current request cannot complete.
- `mem_req`  out  1  memory word-transfer request.
- `mem_we`  out  1  1 = write-back word, 0 = refill read.
- `mem_addr`  out  32  word-aligned byte address; `[1:0]`=0.
- `mem_wdata`  out  32  write-back word.
- `mem_rdata`  in  32  refill word; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle pulse; completes the current word.

## Operation
- Address split: word offset `[LINE_ADDR_LEN+1:2]`; set `[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2]`; tag is the remaining upper bits.
- Per set: valid bit, dirty bit, tag, and `2^LINE_ADDR_LEN` data words.
- `hit` = `valid[set]` and the stored tag equals the address tag.
- `rd_req` and `wr_req` both high: treat as a write.
- FSM states: IDLE, WB, REFILL, FILL_DONE.
- IDLE, request and hit:
  - `miss`=0; `rd_data` = the addressed word.
  - A store updates the bytes selected by `wr_be` at the clock edge and sets `dirty`.
- IDLE, request and miss:
  - `miss`=1 in the same cycle.
  - Next state is WB if the victim is valid and dirty, else REFILL.
  - Word counter `cnt` is cleared to 0.
- WB:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, set, `cnt`, 2'b00}; `mem_wdata` = victim word `cnt`.
  - On `mem_ack`, `cnt` increments. On the ack of the last word, go to REFILL with `cnt`=0.
- REFILL:
  - `mem_req`=1, `mem_we`=0; `mem_addr` = {request tag, set, `cnt`, 2'b00}.
  - On `mem_ack`, write `mem_rdata` into word `cnt` and increment `cnt`. On the last word, go to FILL_DONE.
- FILL_DONE: write tag, set `valid`=1 and `dirty`=0, go to IDLE. The held request then hits; a store sets dirty at that point.
- `miss` = (request and not hit in IDLE) or state ≠ IDLE.
- Request dropped mid-miss: the miss sequence still completes.
- `mem_ack` while `mem_req`=0: ignored.
- `cnt` width is `LINE_ADDR_LEN`; it wraps only at the state transition.

## Timing
- Reset (async, any state, including mid-transfer):
  - State IDLE; all valid/dirty bits, tags and data cleared to 0.
  - `cnt`=0; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `miss`=0 and `rd_data`=0 when no request is present.
- Hit latency: 0 cycles (combinational result; a store commits at the edge).
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered. They stay stable from assertion through the `mem_ack` cycle, then move to the next word on the following cycle (no idle gap).
- Clean-miss penalty: W + N(L+1) cycles with W = 1 (IDLE detect) + 1 (FILL_DONE), N = words per line, L = memory ack latency. Dirty miss adds N(L+1).
- Back-to-back `mem_ack` on consecutive cycles must be accepted, one word each.

## Test plan
- Reset, then load from 0x0000_0040 with ack latency 2: `miss` high, 4 reads at 0x40, 0x44, 0x48, 0x4C, then the hit returns the memory word from 0x40; repeating the load gives `miss`=0 in the same cycle.
- Store 0xDEADBEEF with `wr_be`=4'b0011 to a hit word holding 0x11223344 → word becomes 0x1122BEEF and dirty=1; no memory traffic.
- Conflict load at 0x0000_0440 (same set, new tag) after that store → 4 write-backs to 0x40–0x4C carrying the modified line, then 4 refills from 0x440–0x44C.
- Miss on a clean victim → no `mem_we`=1 cycle; `mem_ack` held high continuously → exactly one word per cycle, refill finishes after 4 acks.
- Assert `rst_n`=0 during the 2nd write-back word → outputs go to 0 immediately; after release, a load to 0x40 misses, proving valid was cleared.
- Simultaneous `rd_req`/`wr_req` on a hit → behaves as a store; a stray `mem_ack` in IDLE → no state change.
